// File: rtl/irq_ctrl_pkg.sv
// Shared register map and VEC field layout for the interrupt controller.
// Used by irq_ctrl and any software-facing collateral that decodes its registers.
package irq_ctrl_pkg;

  localparam logic [1:0] ADR_PEND = 2'd0;
  localparam logic [1:0] ADR_MASK = 2'd1;
  localparam logic [1:0] ADR_MODE = 2'd2;
  localparam logic [1:0] ADR_VEC  = 2'd3;

  localparam int VEC_ACTIVE_BIT = 7;
  localparam int VEC_IDX_LSB    = 0;
  localparam int VEC_IDX_W      = 3;

  function automatic logic [7:0] vec_pack(input logic active, input logic [VEC_IDX_W-1:0] idx);
    logic [7:0] v;
    v = '0;
    v[VEC_ACTIVE_BIT] = active;
    v[VEC_IDX_LSB +: VEC_IDX_W] = idx;
    return v;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: bit 0 is highest priority, idx is 0 when nothing is requested.
module irq_prio_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic [2:0]         idx_o,
  output logic               valid_o
);

  // NOTE: outputs get a default before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Wishbone interrupt controller: PEND/MASK/MODE/VEC registers and a registered CPU interrupt.
// Define IRQ_CTRL_EDGE_EN to build edge-mode support (MODE register, irq_q2, W1C clears).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         wb_adr_i,
  input  logic [7:0]         wb_dat_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [7:0]         wb_dat_o,
  output logic               wb_ack_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               cpu_irq_o
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_rd;
  logic [NUM_IRQ-1:0] wr_data;
  logic               cpu_irq_q, cpu_irq_d;
  logic               wr;
  logic [2:0]         vec_idx;
  logic               vec_valid;

  assign wb_ack_o = wb_stb_i & wb_cyc_i;
  assign wr       = wb_ack_o & wb_we_i;
  assign wr_data  = wb_dat_i[NUM_IRQ-1:0];

  always_comb begin
    mask_d = mask_q;
    if (wr && wb_adr_i == ADR_MASK) mask_d = wr_data;
    cpu_irq_d = |(pend_q & mask_q);
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] irq_q2;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] rise, w1c, mode_chg;
  logic [1:0]         armed_q;

  always_comb begin
    mode_d = mode_q;
    if (wr && wb_adr_i == ADR_MODE) mode_d = wr_data;
    // armed_q[1] marks that irq_q2 holds a sample taken after reset release.
    rise     = irq_q & ~irq_q2 & {NUM_IRQ{armed_q[1]}};
    w1c      = (wr && wb_adr_i == ADR_PEND) ? wr_data : '0;
    mode_chg = mode_d ^ mode_q;
    pend_d   = (mode_q & (rise | (pend_q & ~w1c))) | (~mode_q & irq_q);
    pend_d   = pend_d & ~mode_chg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q2  <= '0;
      mode_q  <= '0;
      armed_q <= '0;
    end else begin
      irq_q2  <= irq_q;
      mode_q  <= mode_d;
      armed_q <= {armed_q[0], 1'b1};
    end
  end

  assign mode_rd = mode_q;
`else
  // Every source is level-sensitive: pend simply tracks the synchronised request.
  always_comb begin
    pend_d = irq_q;
  end

  assign mode_rd = '0;
`endif

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q     <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      cpu_irq_q <= 1'b0;
    end else begin
      irq_q     <= irq_i;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      cpu_irq_q <= cpu_irq_d;
    end
  end

  assign cpu_irq_o = cpu_irq_q;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req_i   (pend_q & mask_q),
    .idx_o   (vec_idx),
    .valid_o (vec_valid)
  );

  always_comb begin
    wb_dat_o = '0;
    unique case (wb_adr_i)
      ADR_PEND: wb_dat_o[NUM_IRQ-1:0] = pend_q;
      ADR_MASK: wb_dat_o[NUM_IRQ-1:0] = mask_q;
      ADR_MODE: wb_dat_o[NUM_IRQ-1:0] = mode_rd;
      ADR_VEC:  wb_dat_o = vec_pack(vec_valid, vec_idx);
      default:  wb_dat_o = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: level path, priority, masking, width limits, reset, and
// (with IRQ_CTRL_EDGE_EN) edge capture, set-vs-clear collision and mode-change clearing.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic       wb_we_i, wb_cyc_i, wb_stb_i;
  logic [7:0] wb_dat_o, n4_dat_o;
  logic       wb_ack_o, n4_ack_o;
  logic [7:0] irq_i;
  logic       cpu_irq_o, n4_cpu_irq_o;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] d, d4;

  always #5 clk_i = ~clk_i;

  irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .irq_i(irq_i), .cpu_irq_o(cpu_irq_o)
  );

  irq_ctrl #(.NUM_IRQ(4)) dut_n4 (
    .clk_i(clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(n4_dat_o), .wb_ack_o(n4_ack_o), .irq_i(irq_i[3:0]), .cpu_irq_o(n4_cpu_irq_o)
  );

  // All stimulus is applied just after a falling edge; outputs are sampled there too.
  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] dat);
    wb_adr_i = adr; wb_dat_i = dat; wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(negedge clk_i);
    wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_dat_i = '0;
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [7:0] dat, output logic [7:0] dat4);
    wb_adr_i = adr; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    #1;
    dat = wb_dat_o; dat4 = n4_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    if (cpu_irq_o !== 1'b0) begin $display("FAIL reset_cpu_irq: got %b want 0", cpu_irq_o); n_mis++; end
    n_cmp++;
    if (wb_ack_o !== 1'b0) begin $display("FAIL ack_idle: got %b want 0", wb_ack_o); n_mis++; end
    n_cmp++;
    wb_stb_i = 1'b1; #1;
    if (wb_ack_o !== 1'b0) begin $display("FAIL ack_stb_no_cyc: got %b want 0", wb_ack_o); n_mis++; end
    n_cmp++;
    wb_cyc_i = 1'b1; #1;
    if (wb_ack_o !== 1'b1) begin $display("FAIL ack_stb_cyc: got %b want 1", wb_ack_o); n_mis++; end
    n_cmp++;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    wb_read(ADR_MASK, d, d4);
    if (d !== 8'h00) begin $display("FAIL reset_mask: got %h want 00", d); n_mis++; end
    n_cmp++;
    wb_read(ADR_VEC, d, d4);
    if (d !== 8'h00) begin $display("FAIL reset_vec: got %h want 00", d); n_mis++; end
    n_cmp++;
  endtask

  task automatic test_level;
    wb_write(ADR_MASK, 8'h04);
    irq_i = 8'h04;
    step(2);
    if (cpu_irq_o !== 1'b0) begin $display("FAIL level_cpu_after_e1: got %b want 0", cpu_irq_o); n_mis++; end
    n_cmp++;
    wb_read(ADR_PEND, d, d4);
    if (d !== 8'h04) begin $display("FAIL level_pend: got %h want 04", d); n_mis++; end
    n_cmp++;
    step(1);
    if (cpu_irq_o !== 1'b1) begin $display("FAIL level_cpu_after_e2: got %b want 1", cpu_irq_o); n_mis++; end
    n_cmp++;
    wb_read(ADR_VEC, d, d4);
    if (d !== 8'h82) begin $display("FAIL level_vec: got %h want 82", d); n_mis++; end
    n_cmp++;
    irq_i = 8'h00;
    step(2);
    if (cpu_irq_o !== 1'b1) begin $display("FAIL level_fall_e1: got %b want 1", cpu_irq_o); n_mis++; end
    n_cmp++;
    step(1);
    if (cpu_irq_o !== 1'b0) begin $display("FAIL level_fall_e2: got %b want 0", cpu_irq_o); n_mis++; end
    n_cmp++;
  endtask

  task automatic test_priority;
    irq_i = 8'h28;
    wb_write(ADR_MASK, 8'hFF);
    step(2);
    wb_read(ADR_VEC, d, d4);
    if (d !== 8'h83) begin $display("FAIL prio_vec_ff: got %h want 83", d); n_mis++; end
    n_cmp++;
    if (cpu_irq_o !== 1'b1) begin $display("FAIL prio_cpu: got %b want 1", cpu_irq_o); n_mis++; end
    n_cmp++;
    wb_read(ADR_MASK, d, d4);
    if (d4 !== 8'h0F) begin $display("FAIL n4_mask_width: got %h want 0f", d4); n_mis++; end
    n_cmp++;
    wb_read(ADR_PEND, d, d4);
    if (d4 !== 8'h08) begin $display("FAIL n4_pend_width: got %h want 08", d4); n_mis++; end
    n_cmp++;
    wb_write(ADR_MASK, 8'hF0);
    wb_read(ADR_VEC, d, d4);
    if (d !== 8'h85) begin $display("FAIL prio_vec_f0: got %h want 85", d); n_mis++; end
    n_cmp++;
    if (d4 !== 8'h00) begin $display("FAIL n4_vec_masked: got %h want 00", d4); n_mis++; end
    n_cmp++;
    wb_write(ADR_MASK, 8'h00);
    wb_read(ADR_VEC, d, d4);
    if (d !== 8'h00) begin $display("FAIL prio_vec_none: got %h want 00", d); n_mis++; end
    n_cmp++;
    irq_i = 8'h00;
    step(3);
  endtask

  task automatic test_masking;
    irq_i = 8'h01;
    step(3);
    if (cpu_irq_o !== 1'b0) begin $display("FAIL mask_cpu_masked: got %b want 0", cpu_irq_o); n_mis++; end
    n_cmp++;
    wb_read(ADR_PEND, d, d4);
    if (d !== 8'h01) begin $display("FAIL mask_pend_masked: got %h want 01", d); n_mis++; end
    n_cmp++;
    wb_write(ADR_PEND, 8'h01);
    wb_read(ADR_PEND, d, d4);
    if (d !== 8'h01) begin $display("FAIL level_w1c_ignored: got %h want 01", d); n_mis++; end
    n_cmp++;
    wb_write(ADR_MASK, 8'h01);
    if (cpu_irq_o !== 1'b0) begin $display("FAIL unmask_same_edge: got %b want 0", cpu_irq_o); n_mis++; end
    n_cmp++;
    step(1);
    if (cpu_irq_o !== 1'b1) begin $display("FAIL unmask_next_edge: got %b want 1", cpu_irq_o); n_mis++; end
    n_cmp++;
  endtask

`ifdef IRQ_CTRL_EDGE_EN
  task automatic test_edge;
    wb_write(ADR_MODE, 8'h01);
    wb_write(ADR_MASK, 8'h01);
    irq_i = 8'h01;
    step(1);
    irq_i = 8'h00;
    step(8);
    wb_read(ADR_PEND, d, d4);
    if (d !== 8'h01) begin $display("FAIL edge_pend_held: got %h want 01", d); n_mis++; end
    n_cmp++;
    if (cpu_irq_o !== 1'b1) begin $display("FAIL edge_cpu: got %b want 1", cpu_irq_o); n_mis++; end
    n_cmp++;
    wb_write(ADR_PEND, 8'h01);
    wb_read(ADR_PEND, d, d4);
    if (d !== 8'h00) begin $display("FAIL edge_w1c: got %h want 00", d); n_mis++; end
    n_cmp++;
    step(1);
    if (cpu_irq_o !== 1'b0) begin $display("FAIL edge_cpu_clear: got %b want 0", cpu_irq_o); n_mis++; end
    n_cmp++;
  endtask

  task automatic test_collision;
    irq_i = 8'h01; step(1); irq_i = 8'h00; step(3);
    irq_i = 8'h01;
    step(1);
    wb_write(ADR_PEND, 8'h01);
    wb_read(ADR_PEND, d, d4);
    if (d !== 8'h01) begin $display("FAIL collision_set_wins: got %h want 01", d); n_mis++; end
    n_cmp++;
    step(1);
    wb_write(ADR_PEND, 8'h01);
    wb_read(ADR_PEND, d, d4);
    if (d !== 8'h00) begin $display("FAIL edge_steady_high_clear: got %h want 00", d); n_mis++; end
    n_cmp++;
  endtask

  task automatic test_mode_change;
    irq_i = 8'h00; step(2); irq_i = 8'h01; step(3);
    wb_write(ADR_MODE, 8'h00);
    wb_read(ADR_PEND, d, d4);
    if (d !== 8'h00) begin $display("FAIL mode_change_clear: got %h want 00", d); n_mis++; end
    n_cmp++;
    step(1);
    wb_read(ADR_PEND, d, d4);
    if (d !== 8'h01) begin $display("FAIL mode_change_reeval: got %h want 01", d); n_mis++; end
    n_cmp++;
    irq_i = 8'h00;
    wb_write(ADR_MASK, 8'h00);
    step(3);
  endtask
`else
  task automatic test_edge_disabled;
    wb_write(ADR_MODE, 8'hFF);
    wb_read(ADR_MODE, d, d4);
    if (d !== 8'h00) begin $display("FAIL mode_reads_zero: got %h want 00", d); n_mis++; end
    n_cmp++;
  endtask
`endif

  task automatic test_reset_midop;
    if (cpu_irq_o !== 1'b1) begin $display("FAIL midop_precondition: got %b want 1", cpu_irq_o); n_mis++; end
    n_cmp++;
    #2 rst_i = 1'b1;
    #1;
    if (cpu_irq_o !== 1'b0) begin $display("FAIL midop_cpu: got %b want 0", cpu_irq_o); n_mis++; end
    n_cmp++;
    wb_read(ADR_PEND, d, d4);
    if (d !== 8'h00) begin $display("FAIL midop_pend: got %h want 00", d); n_mis++; end
    n_cmp++;
    wb_read(ADR_MASK, d, d4);
    if (d !== 8'h00) begin $display("FAIL midop_mask: got %h want 00", d); n_mis++; end
    n_cmp++;
    wb_read(ADR_MODE, d, d4);
    if (d !== 8'h00) begin $display("FAIL midop_mode: got %h want 00", d); n_mis++; end
    n_cmp++;
    wb_read(ADR_VEC, d, d4);
    if (d !== 8'h00) begin $display("FAIL midop_vec: got %h want 00", d); n_mis++; end
    n_cmp++;
    step(1);
    rst_i = 1'b0;
    irq_i = 8'h00;
  endtask

  initial begin
    rst_i = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; irq_i = '0;
    test_reset;
    step(1);
    rst_i = 1'b0;
    step(1);
    test_level;
    test_priority;
`ifdef IRQ_CTRL_EDGE_EN
    test_edge;
    test_collision;
    test_mode_change;
`else
    test_edge_disabled;
`endif
    test_masking;
    test_reset_midop;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt sources (1..8).
REQ-002 SHALL have port clk_i  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wb_adr_i  input  2  Wishbone register address.
REQ-005 SHALL have port wb_dat_i  input  8  Wishbone write data.
REQ-006 SHALL have port wb_we_i  input  1  Wishbone write enable.
REQ-007 SHALL have port wb_cyc_i  input  1  Wishbone cycle.
REQ-008 SHALL have port wb_stb_i  input  1  Wishbone strobe.
REQ-009 SHALL have port wb_dat_o  output  8  Wishbone read data.
REQ-010 SHALL have port wb_ack_o  output  1  Wishbone acknowledge.
REQ-011 SHALL have port irq_i  input  NUM_IRQ  interrupt requests from timer/interrupt-generator blocks, bit 0 highest priority.
REQ-012 SHALL have port cpu_irq_o  output  1  aggregated interrupt to CPU, registered.

Function
REQ-013 SHALL assert wb_ack_o = wb_stb_i & wb_cyc_i combinationally: zero wait states, one access per cycle.
REQ-014 SHALL decode a write as wb_stb_i & wb_cyc_i & wb_we_i, sampled on the clock edge.
REQ-015 SHALL implement registers: 0 PEND (R, W1C), 1 MASK (R/W, 1 = enabled), 2 MODE (R/W, 1 = edge), 3 VEC (R).
REQ-016 SHALL register irq_i into irq_q every cycle; irq_q2 SHALL hold the previous value of irq_q.
REQ-017 In level mode, pend[i] SHALL be loaded with irq_q[i] every cycle; W1C writes SHALL have no effect on level-mode bits.
REQ-018 In edge mode, pend[i] SHALL be set when irq_q[i] & ~irq_q2[i]; it SHALL be cleared only by a PEND write with bit i = 1.
REQ-019 If an edge and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-020 cpu_irq_o SHALL be registered as |(pend & mask). irq_i high before edge E0 -> pend at E1 -> cpu_irq_o high after E2, for both modes.
REQ-021 VEC read SHALL return {active, 4'b0, idx[2:0]}. active = |(pend & mask); idx = lowest set bit index of pend & mask; idx = 0 when none is set.
REQ-022 Reads SHALL be combinational from current register state and SHALL have no side effects.
REQ-023 Bits at or above NUM_IRQ SHALL read 0 and ignore writes.
REQ-024 A MODE bit change SHALL clear that pend bit in the same cycle; re-evaluation starts the next cycle.
REQ-025 Changing MASK SHALL NOT alter pend; a masked pending bit SHALL reappear at cpu_irq_o one edge after unmasking.

Reset
REQ-026 On rst_i: pend, irq_q, irq_q2, MASK, MODE SHALL be 0 and cpu_irq_o SHALL be 0, asynchronously.
REQ-027 Reset mid-operation SHALL drop any pending interrupt. Edges present before reset release SHALL NOT be captured until irq_q2 has a post-reset sample.

Configuration
REQ-028 Macro IRQ_CTRL_EDGE_EN SHALL, when defined, compile in edge mode: the MODE register, irq_q2, and W1C logic.
REQ-029 Without IRQ_CTRL_EDGE_EN, all sources SHALL be level mode. MODE SHALL read 0 and ignore writes, and PEND writes SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the register address constants (ADR_PEND=0, ADR_MASK=1, ADR_MODE=2, ADR_VEC=3) and the VEC field positions.
REQ-031 The priority encoder SHALL be a sub-module irq_prio_enc (NUM_IRQ-bit in, 3-bit idx, valid out).

Verification
REQ-032 Level path: MASK=0x04, irq_i[2] high -> cpu_irq_o=1 two edges later, VEC=0x82. irq_i[2] low -> cpu_irq_o=0 two edges later.
REQ-033 Priority: MASK=0xFF, irq_i=0x28 -> VEC=0x83. Then MASK=0xF0 -> VEC=0x85.
REQ-034 Edge capture (IRQ_CTRL_EDGE_EN): MODE=0x01, MASK=0x01, one-cycle pulse on irq_i[0] -> PEND=0x01 held. Write PEND=0x01 -> PEND=0x00, cpu_irq_o=0 next edge.
REQ-035 Set-vs-clear collision: rising edge on irq_i[0] in the same cycle as a PEND=0x01 write -> PEND remains 0x01.
REQ-036 Masking: irq_i=0x01, MASK=0x00 -> cpu_irq_o=0 and PEND=0x01. Write MASK=0x01 -> cpu_irq_o=1 after one edge.
REQ-037 Reset mid-operation: cpu_irq_o=1, assert rst_i -> cpu_irq_o, PEND, MASK, MODE all 0 immediately. Reads return 0x00.
